// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped peripheral block:
// register offsets, control-bit positions and the UART frame state encoding.
package mmio_pkg;

    localparam logic [23:0] BASE_HI   = 24'h40_0000;

    localparam logic [7:0]  ADDR_TH   = 8'h00;
    localparam logic [7:0]  ADDR_TL   = 8'h04;
    localparam logic [7:0]  ADDR_TCON = 8'h08;
    localparam logic [7:0]  ADDR_LED  = 8'h0C;
    localparam logic [7:0]  ADDR_TXD  = 8'h18;
    localparam logic [7:0]  ADDR_RXD  = 8'h1C;
    localparam logic [7:0]  ADDR_UCON = 8'h20;

    localparam int TCON_RUN       = 0;
    localparam int TCON_TIRQ_EN   = 1;
    localparam int TCON_TIRQ_PEND = 2;

    localparam int UCON_RX_IRQ_EN = 0;
    localparam int UCON_TX_IRQ_EN = 1;
    localparam int UCON_RX_VALID  = 2;
    localparam int UCON_TX_DONE   = 3;
    localparam int UCON_TX_BUSY   = 4;
    localparam int UCON_OVERRUN   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic logic [31:0] zext8(input logic [7:0] v);
        return {24'h00_0000, v};
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchronizer, mid-bit sampling FSM, and a registered
// byte output with a one-cycle done pulse for frames that end in a valid stop bit.
module uart_rx
    import mmio_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_done
);

    localparam int             CW        = $clog2(DIV + 1);
    localparam logic [CW-1:0]  DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]  ONE       = CW'(1);
    localparam logic [CW-1:0]  ZERO      = CW'(0);

    logic        sync1_q, sync2_q, prev_q;
    uart_state_e state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shr_q, shr_d;
    logic [7:0]  byte_q, byte_d;
    logic        done_q, done_d;

    // Synchronizer; prev_q gives the falling-edge reference
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= ZERO;
            bit_q   <= 3'd0;
            shr_q   <= 8'h00;
            byte_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shr_q   <= shr_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
        end
    end

    // Next state: start bit checked half a bit in, later bits one bit apart
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shr_d   = shr_q;
        case (state_q)
            IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = START;
                    div_d   = ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (div_q == HALF_LAST) begin
                    div_d   = ZERO;
                    bit_d   = 3'd0;
                    state_d = sync2_q ? IDLE : DATA;
                end else begin
                    div_d = div_q + ONE;
                end
            end
            DATA: begin
                if (div_q == DIV_LAST) begin
                    div_d = ZERO;
                    shr_d = {sync2_q, shr_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + ONE;
                end
            end
            STOP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = ZERO;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: a bad stop bit discards the frame silently
    always_comb begin
        done_d = (state_q == STOP) && (div_q == DIV_LAST) && sync2_q;
        if (done_d) begin
            byte_d = shr_q;
        end else begin
            byte_d = byte_q;
        end
    end

    assign rx_byte = byte_q;
    assign rx_done = done_q;

endmodule

// File: rtl/mmio_peripherals.sv
// Peripheral slave at 0x4000_00xx: reloading timer, LED register and UART,
// with a combinational read mux and a level interrupt built from status flops.
module mmio_peripherals
    import mmio_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq
);

    localparam int            DIV      = CLK_HZ / BAUD;
    localparam int            CW       = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ZERO     = CW'(0);

    logic        hit_s, unused_addr_s;
    logic [7:0]  off_s;
    logic        wr_th_s, wr_tl_s, wr_tcon_s, wr_led_s, wr_txd_s, wr_ucon_s;
    logic        rd_rxd_s, rd_ucon_s;

    logic [31:0] th_q, th_d, tl_q, tl_d;
    logic        run_q, run_d, ten_q, ten_d, tpend_q, tpend_d, tirq_set_s;
    logic [7:0]  led_q, led_d;
    logic        rx_irq_en_q, rx_irq_en_d, tx_irq_en_q, tx_irq_en_d;
    logic        rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic        tx_done_q, tx_done_d, tx_done_set_s;
    logic [7:0]  rxd_q, rxd_d, rx_byte_s;
    logic        rx_done_s;

    uart_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_div_q, tx_div_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shr_q, tx_shr_d;
    logic          uart_tx_q, uart_tx_d;

    assign hit_s         = (addr[31:8] == BASE_HI);
    assign off_s         = {addr[7:2], 2'b00};
    assign unused_addr_s = ^addr[1:0];
    assign wr_th_s       = wr && hit_s && (off_s == ADDR_TH);
    assign wr_tl_s       = wr && hit_s && (off_s == ADDR_TL);
    assign wr_tcon_s     = wr && hit_s && (off_s == ADDR_TCON);
    assign wr_led_s      = wr && hit_s && (off_s == ADDR_LED);
    assign wr_txd_s      = wr && hit_s && (off_s == ADDR_TXD);
    assign wr_ucon_s     = wr && hit_s && (off_s == ADDR_UCON);
    assign rd_rxd_s      = rd && hit_s && (off_s == ADDR_RXD);
    assign rd_ucon_s     = rd && hit_s && (off_s == ADDR_UCON);

    uart_rx #(.DIV(DIV)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rx_in   (uart_rx),
        .rx_byte (rx_byte_s),
        .rx_done (rx_done_s)
    );

    // Timer: CPU write to TL beats the count; a hardware pend set beats a clear
    always_comb begin
        th_d       = wr_th_s ? wdata : th_q;
        tirq_set_s = run_q && ten_q && (tl_q == 32'hFFFF_FFFF);
        if (wr_tl_s) begin
            tl_d = wdata;
        end else if (run_q) begin
            tl_d = (tl_q == 32'hFFFF_FFFF) ? th_q : tl_q + 32'd1;
        end else begin
            tl_d = tl_q;
        end
        if (wr_tcon_s) begin
            run_d   = wdata[TCON_RUN];
            ten_d   = wdata[TCON_TIRQ_EN];
            tpend_d = tirq_set_s || (tpend_q && wdata[TCON_TIRQ_PEND]);
        end else begin
            run_d   = run_q;
            ten_d   = ten_q;
            tpend_d = tirq_set_s || tpend_q;
        end
    end

    // LED, UART control and status flags; hardware sets beat read-clears
    always_comb begin
        led_d       = wr_led_s  ? wdata[7:0] : led_q;
        rx_irq_en_d = wr_ucon_s ? wdata[UCON_RX_IRQ_EN] : rx_irq_en_q;
        tx_irq_en_d = wr_ucon_s ? wdata[UCON_TX_IRQ_EN] : tx_irq_en_q;
        rx_valid_d  = rx_done_s || (rx_valid_q && !rd_rxd_s);
        overrun_d   = (rx_done_s && rx_valid_q) || (overrun_q && !rd_rxd_s);
        rxd_d       = rx_done_s ? rx_byte_s : rxd_q;
        tx_done_d   = tx_done_set_s || (tx_done_q && !rd_ucon_s);
    end

    // TX FSM next state; writes outside IDLE are dropped
    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shr_d   = tx_shr_q;
        case (tx_state_q)
            IDLE: begin
                if (wr_txd_s) begin
                    tx_state_d = START;
                    tx_div_d   = ZERO;
                    tx_shr_d   = wdata[7:0];
                end else begin
                    tx_state_d = IDLE;
                end
            end
            START: begin
                if (tx_div_q == DIV_LAST) begin
                    tx_div_d   = ZERO;
                    tx_bit_d   = 3'd0;
                    tx_state_d = DATA;
                end else begin
                    tx_div_d = tx_div_q + ONE;
                end
            end
            DATA: begin
                if (tx_div_q == DIV_LAST) begin
                    tx_div_d = ZERO;
                    tx_shr_d = {1'b0, tx_shr_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_div_d = tx_div_q + ONE;
                end
            end
            STOP: begin
                if (tx_div_q == DIV_LAST) begin
                    tx_div_d   = ZERO;
                    tx_state_d = IDLE;
                end else begin
                    tx_div_d = tx_div_q + ONE;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // TX outputs: line level follows the state being entered
    always_comb begin
        tx_done_set_s = (tx_state_q == STOP) && (tx_div_q == DIV_LAST);
        case (tx_state_d)
            START:   uart_tx_d = 1'b0;
            DATA:    uart_tx_d = tx_shr_d[0];
            default: uart_tx_d = 1'b1;
        endcase
    end

    // Register file and TX state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q        <= 32'h0000_0000;
            tl_q        <= 32'h0000_0000;
            run_q       <= 1'b0;
            ten_q       <= 1'b0;
            tpend_q     <= 1'b0;
            led_q       <= 8'h00;
            rx_irq_en_q <= 1'b0;
            tx_irq_en_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            rxd_q       <= 8'h00;
            tx_state_q  <= IDLE;
            tx_div_q    <= ZERO;
            tx_bit_q    <= 3'd0;
            tx_shr_q    <= 8'h00;
            uart_tx_q   <= 1'b1;
        end else begin
            th_q        <= th_d;
            tl_q        <= tl_d;
            run_q       <= run_d;
            ten_q       <= ten_d;
            tpend_q     <= tpend_d;
            led_q       <= led_d;
            rx_irq_en_q <= rx_irq_en_d;
            tx_irq_en_q <= tx_irq_en_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            tx_done_q   <= tx_done_d;
            rxd_q       <= rxd_d;
            tx_state_q  <= tx_state_d;
            tx_div_q    <= tx_div_d;
            tx_bit_q    <= tx_bit_d;
            tx_shr_q    <= tx_shr_d;
            uart_tx_q   <= uart_tx_d;
        end
    end

    // Read mux: shows pre-write state when rd and wr coincide
    always_comb begin
        rdata = 32'h0000_0000;
        if (rd && hit_s) begin
            case (off_s)
                ADDR_TH:   rdata = th_q;
                ADDR_TL:   rdata = tl_q;
                ADDR_TCON: rdata = {29'h0, tpend_q, ten_q, run_q};
                ADDR_LED:  rdata = zext8(led_q);
                ADDR_RXD:  rdata = zext8(rxd_q);
                ADDR_UCON: rdata = {26'h0, overrun_q, (tx_state_q != IDLE),
                                    tx_done_q, rx_valid_q, tx_irq_en_q, rx_irq_en_q};
                default:   rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    assign led     = led_q;
    assign uart_tx = uart_tx_q;
    assign irq     = (ten_q && tpend_q) || (rx_irq_en_q && rx_valid_q) ||
                     (tx_irq_en_q && tx_done_q);

endmodule
